// File: rtl/elevator_fsm.sv
// Two-floor elevator sequencer: latches calls, runs the floor/travel state machine
// and produces the registered state/countdown pair that drives the motor controller.
module elevator_fsm #(
  parameter int unsigned TICK_DIV    = 50000000,
  parameter logic [2:0]  TRAVEL_TIME = 3'd5,
  parameter logic [2:0]  DOOR_TIME   = 3'd3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_floor1,
  input  logic       btn_floor2,
  output logic [2:0] state,
  output logic [2:0] counting_value,
  output logic       door_open,
  output logic [1:0] req_pending
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FLOOR1 = 3'd1,
    S_FLOOR2 = 3'd2,
    S_GO1    = 3'd3,
    S_GO2    = 3'd4
  } state_e;

  localparam int unsigned     PW        = $clog2(TICK_DIV);
  localparam logic [PW-1:0]   PRESC_MAX = PW'(TICK_DIV - 1);

  state_e        state_q, state_d;
  logic [2:0]    count_q, count_d;
  logic          door_q, door_d;
  logic [1:0]    req_q, req_d;
  logic [PW-1:0] presc_q;
  logic          tick_s;
  logic          load_s;
  logic [1:0]    latch_mask_s;
  logic          own_btn_s;
  logic          other_pend_s;

  assign tick_s = (presc_q == PRESC_MAX);

  // Next-state, countdown, door and call-latch decisions.
  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    door_d       = door_q;
    load_s       = 1'b0;
    own_btn_s    = 1'b0;
    other_pend_s = 1'b0;

    // A call is dropped when it names the floor the car is at or is heading to.
    case (state_q)
      S_IDLE:   latch_mask_s = 2'b11;
      S_FLOOR1: latch_mask_s = 2'b10;
      S_FLOOR2: latch_mask_s = 2'b01;
      S_GO1:    latch_mask_s = 2'b10;
      S_GO2:    latch_mask_s = 2'b01;
      default:  latch_mask_s = 2'b00;
    endcase
    req_d = req_q | ({btn_floor2, btn_floor1} & latch_mask_s);

    case (state_q)
      S_IDLE: begin
        if (req_q[0] || btn_floor1) begin
          state_d  = S_FLOOR1;
          count_d  = DOOR_TIME;
          door_d   = 1'b1;
          req_d[0] = 1'b0;
          load_s   = 1'b1;
        end else if (req_q[1] || btn_floor2) begin
          state_d  = S_GO2;
          count_d  = TRAVEL_TIME;
          door_d   = 1'b0;
          req_d[1] = 1'b0;
          load_s   = 1'b1;
        end else begin
          door_d = 1'b0;
        end
      end
      S_FLOOR1, S_FLOOR2: begin
        own_btn_s    = (state_q == S_FLOOR1) ? btn_floor1 : btn_floor2;
        other_pend_s = (state_q == S_FLOOR1) ? req_q[1] : req_q[0];
        if (own_btn_s) begin
          count_d = DOOR_TIME;
          door_d  = 1'b1;
          load_s  = 1'b1;
        end else if (tick_s && (count_q != 3'd0)) begin
          count_d = count_q - 3'd1;
          door_d  = (count_q != 3'd1);
        end else if (tick_s && other_pend_s) begin
          state_d = (state_q == S_FLOOR1) ? S_GO2 : S_GO1;
          count_d = TRAVEL_TIME;
          door_d  = 1'b0;
          load_s  = 1'b1;
        end else begin
          state_d = state_q;
        end
      end
      S_GO1, S_GO2: begin
        door_d = 1'b0;
        if (tick_s && (count_q != 3'd0)) begin
          count_d = count_q - 3'd1;
        end else if (tick_s) begin
          // The zero-count tick is the settle/brake interval before the door opens.
          state_d = (state_q == S_GO1) ? S_FLOOR1 : S_FLOOR2;
          count_d = DOOR_TIME;
          door_d  = 1'b1;
          load_s  = 1'b1;
          if (state_q == S_GO1) begin
            req_d[0] = 1'b0;
          end else begin
            req_d[1] = 1'b0;
          end
        end else begin
          count_d = count_q;
        end
      end
      default: begin
        state_d = S_IDLE;
        count_d = 3'd0;
        door_d  = 1'b0;
        load_s  = 1'b1;
      end
    endcase
  end

  // State, output and prescaler registers; the prescaler restarts with every countdown load.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      count_q <= 3'd0;
      door_q  <= 1'b0;
      req_q   <= 2'b00;
      presc_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      door_q  <= door_d;
      req_q   <= req_d;
      if (load_s || tick_s) begin
        presc_q <= '0;
      end else begin
        presc_q <= presc_q + PW'(1);
      end
    end
  end

  assign state          = state_q;
  assign counting_value = count_q;
  assign door_open      = door_q;
  assign req_pending    = req_q;

endmodule

// File: tb/tb_elevator_fsm.sv
// Bench for elevator_fsm: directed scenarios with literal expectations, then random
// calls and resets checked every cycle against a car-level behavioural model.
module tb_elevator_fsm;

  localparam int TD = 4;
  localparam int TT = 5;
  localparam int DT = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_floor1 = 1'b0;
  logic       btn_floor2 = 1'b0;
  logic [2:0] state;
  logic [2:0] counting_value;
  logic       door_open;
  logic [1:0] req_pending;

  int n_cmp = 0;
  int n_err = 0;

  elevator_fsm #(
    .TICK_DIV   (TD),
    .TRAVEL_TIME(3'd5),
    .DOOR_TIME  (3'd3)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .btn_floor1    (btn_floor1),
    .btn_floor2    (btn_floor2),
    .state         (state),
    .counting_value(counting_value),
    .door_open     (door_open),
    .req_pending   (req_pending)
  );

  always #5 clk = ~clk;

  // Car model: where 0 = unknown/idle, 1/2 = parked at that floor, 3 = moving to target.
  int m_where  = 0;
  int m_target = 0;
  int m_timer  = 0;
  bit m_door   = 1'b0;
  bit m_call [1:2];
  int m_since  = 0;

  function automatic void check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic int exp_state();
    if (m_where == 3) return (m_target == 1) ? 3 : 4;
    return m_where;
  endfunction

  task automatic model_step(input bit r, input bit b1, input bit b2);
    bit btn [1:2];
    bit old [1:2];
    bit tick;
    bit loaded;
    int here;
    int other;
    if (r) begin
      m_where = 0; m_target = 0; m_timer = 0; m_door = 1'b0;
      m_call[1] = 1'b0; m_call[2] = 1'b0; m_since = 0;
      return;
    end
    btn[1] = b1; btn[2] = b2;
    old[1] = m_call[1]; old[2] = m_call[2];
    tick   = ((m_since % TD) == TD - 1);
    loaded = 1'b0;
    for (int f = 1; f <= 2; f++) begin
      if (btn[f] && m_where != f && !(m_where == 3 && m_target == f)) m_call[f] = 1'b1;
    end
    if (m_where == 0) begin
      if (old[1] || b1) begin
        m_where = 1; m_timer = DT; m_door = 1'b1; m_call[1] = 1'b0; loaded = 1'b1;
      end else if (old[2] || b2) begin
        m_where = 3; m_target = 2; m_timer = TT; m_door = 1'b0; m_call[2] = 1'b0; loaded = 1'b1;
      end
    end else if (m_where == 3) begin
      if (tick) begin
        if (m_timer > 0) m_timer--;
        else begin
          m_where = m_target; m_timer = DT; m_door = 1'b1; m_call[m_target] = 1'b0; loaded = 1'b1;
        end
      end
    end else begin
      here  = m_where;
      other = 3 - here;
      if (btn[here]) begin
        m_timer = DT; m_door = 1'b1; loaded = 1'b1;
      end else if (tick) begin
        if (m_timer > 0) begin
          m_timer--;
          m_door = (m_timer > 0);
        end else if (old[other]) begin
          m_where = 3; m_target = other; m_timer = TT; m_door = 1'b0; loaded = 1'b1;
        end
      end
    end
    m_since = loaded ? 0 : m_since + 1;
  endtask

  // Per-cycle comparison of the DUT against the model, just after each rising edge.
  initial begin
    bit c_rst, c_b1, c_b2;
    m_call[1] = 1'b0;
    m_call[2] = 1'b0;
    forever begin
      @(posedge clk);
      c_rst = rst; c_b1 = btn_floor1; c_b2 = btn_floor2;
      #1;
      model_step(c_rst, c_b1, c_b2);
      check("model_state", int'(state), exp_state());
      check("model_count", int'(counting_value), m_timer);
      check("model_door", int'(door_open), int'(m_door));
      check("model_req", int'(req_pending), int'({m_call[2], m_call[1]}));
    end
  end

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_all(input string name, input int s, input int c, input int d, input int r);
    check({name, "_state"}, int'(state), s);
    check({name, "_count"}, int'(counting_value), c);
    check({name, "_door"}, int'(door_open), d);
    check({name, "_req"}, int'(req_pending), r);
  endtask

  initial begin
    wait_n(3);
    rst = 1'b0;
    expect_all("reset", 0, 0, 0, 0);
    wait_n(100);
    expect_all("idle_quiet", 0, 0, 0, 0);

    // Idle -> floor 2 trip.
    btn_floor2 = 1'b1; wait_n(1); btn_floor2 = 1'b0;
    expect_all("go2_entry", 4, 5, 0, 0);
    wait_n(4);
    check("go2_step", int'(counting_value), 4);
    wait_n(20);
    expect_all("arrive2", 2, 3, 1, 0);
    wait_n(12);
    expect_all("door2_closed", 2, 0, 0, 0);

    // Both calls from idle: floor 1 wins, floor 2 stays pending.
    rst = 1'b1; wait_n(1); rst = 1'b0;
    expect_all("reset2", 0, 0, 0, 0);
    btn_floor1 = 1'b1; btn_floor2 = 1'b1; wait_n(1);
    btn_floor1 = 1'b0; btn_floor2 = 1'b0;
    expect_all("both_f1", 1, 3, 1, 2);
    wait_n(12);
    expect_all("door1_closed", 1, 0, 0, 2);
    wait_n(4);
    expect_all("depart_to2", 4, 5, 0, 2);

    // Destination call ignored, origin call latched during travel.
    wait_n(8);
    check("travel_cv3", int'(counting_value), 3);
    btn_floor2 = 1'b1; wait_n(1); btn_floor2 = 1'b0;
    check("dest_call_ignored", int'(req_pending), 2);
    btn_floor1 = 1'b1; wait_n(1); btn_floor1 = 1'b0;
    check("origin_call_latched", int'(req_pending), 3);
    wait_n(14);
    expect_all("arrive2_b", 2, 3, 1, 1);

    // Own-floor reopen at counting_value 1.
    wait_n(8);
    check("door_cv1", int'(counting_value), 1);
    btn_floor2 = 1'b1; wait_n(1); btn_floor2 = 1'b0;
    expect_all("reopen", 2, 3, 1, 1);
    wait_n(12);
    expect_all("door2_closed_b", 2, 0, 0, 1);
    wait_n(4);
    expect_all("depart_to1", 3, 5, 0, 1);

    // Reset mid-travel.
    wait_n(12);
    check("travel1_cv2", int'(counting_value), 2);
    rst = 1'b1; wait_n(1); rst = 1'b0;
    expect_all("reset_travel", 0, 0, 0, 0);

    // Random calls with occasional resets.
    for (int i = 0; i < 4000; i++) begin
      btn_floor1 = ($urandom_range(0, 11) == 0);
      btn_floor2 = ($urandom_range(0, 11) == 0);
      rst        = ($urandom_range(0, 699) == 0);
      wait_n(1);
    end
    btn_floor1 = 1'b0; btn_floor2 = 1'b0; rst = 1'b0;
    wait_n(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
